// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline control unit:
//   - pc_sel_e      : PC-select encodings driven on pc_sel_o
//   - STG_*         : default stage indices of the 5-stage core
//   - REG_W         : architectural register index width
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [1:0] {
    PC_SEL_SEQ = 2'b00,
    PC_SEL_BR  = 2'b01,
    PC_SEL_EXC = 2'b10
  } pc_sel_e;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_hazard
// Combinational load-use detector. Compares the ID source registers against
// the destination of every in-flight load in stages 2..MEM_STAGE.
// Ports:
//   i_id_rs1 / i_id_rs2         : ID source register indices
//   i_id_use_rs1 / i_id_use_rs2 : ID actually reads that source
//   i_ld_rd   : packed rd per stage, stage 2 in the LSBs
//   i_ld_is   : stage holds a load
//   i_ld_live : stage holds a live instruction
//   o_ld_use  : ID must stall
// -----------------------------------------------------------------------------
module pipe_ctrl_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int NLD = 2
) (
  input  logic [REG_W-1:0]     i_id_rs1,
  input  logic [REG_W-1:0]     i_id_rs2,
  input  logic                 i_id_use_rs1,
  input  logic                 i_id_use_rs2,
  input  logic [REG_W*NLD-1:0] i_ld_rd,
  input  logic [NLD-1:0]       i_ld_is,
  input  logic [NLD-1:0]       i_ld_live,
  output logic                 o_ld_use
);

  always_comb begin
    o_ld_use = 1'b0;
    for (int i = 0; i < NLD; i++) begin
      // x0 is hardwired to zero, so a load targeting it never creates a hazard.
      if (i_ld_live[i] && i_ld_is[i] && (i_ld_rd[i*REG_W +: REG_W] != '0) &&
          ((i_id_use_rs1 && (i_ld_rd[i*REG_W +: REG_W] == i_id_rs1)) ||
           (i_id_use_rs2 && (i_ld_rd[i*REG_W +: REG_W] == i_id_rs2)))) begin
        o_ld_use = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control for the in-order core: per-register stall/flush/valid,
// load-use interlock, fetch-wait bubbles, PC-select arbitration and
// cycle/instret counters. Register k sits between stage k and stage k+1.
// Optional macro: PIPE_CTRL_PERF_EN enables the 32-bit stall/flush counters;
// without it stall_cnt_o/flush_cnt_o are constant 0.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   ifetch_ack_i            : IF holds a fetched instruction
//   dmem_req_i/ack_i/err_i  : data-bus status of the MEM-stage instruction
//   id_rs1_i/rs2_i, id_use_rs1_i/rs2_i : ID source operands
//   ld_rd_i, ld_is_i        : rd / is-load of stages 2..MEM_STAGE
//   br_j_taken_i            : taken branch/jump in BR_STAGE
//   exc_taken_i             : trap taken in WB
//   stall_o, flush_o, valid_o : per-register control/status
//   pc_sel_o                : 00 sequential, 01 branch, 10 trap
//   cycle_o, instret_o      : wrapping counters
//   stall_cnt_o, flush_cnt_o: performance counters
// Data-bus handshake: the access of the MEM-stage instruction completes in the
// cycle dmem_ack_i or dmem_err_i is high while dmem_req_i is high; until then
// MEM and every stage before it hold, and a bubble enters the register after
// MEM.
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES   = STG_WB + 1,
  parameter int BR_STAGE  = STG_EXE,
  parameter int MEM_STAGE = STG_MEM,
  parameter int CNT_W     = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           ifetch_ack_i,
  input  logic                           dmem_req_i,
  input  logic                           dmem_ack_i,
  input  logic                           dmem_err_i,
  input  logic [REG_W-1:0]               id_rs1_i,
  input  logic [REG_W-1:0]               id_rs2_i,
  input  logic                           id_use_rs1_i,
  input  logic                           id_use_rs2_i,
  input  logic [REG_W*(MEM_STAGE-1)-1:0] ld_rd_i,
  input  logic [MEM_STAGE-2:0]           ld_is_i,
  input  logic                           br_j_taken_i,
  input  logic                           exc_taken_i,
  output logic [NSTAGES-2:0]             stall_o,
  output logic [NSTAGES-2:0]             flush_o,
  output logic [NSTAGES-2:0]             valid_o,
  output logic [1:0]                     pc_sel_o,
  output logic [CNT_W-1:0]               cycle_o,
  output logic [CNT_W-1:0]               instret_o,
  output logic [31:0]                    stall_cnt_o,
  output logic [31:0]                    flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NSTAGES-2:0] r_valid;
  logic [CNT_W-1:0]   r_cycle;
  logic [CNT_W-1:0]   r_instret;

  // Liveness of stages 0..NSTAGES-2 (WB liveness is only needed as r_valid).
  logic [NSTAGES-2:0] w_live;
  logic [NSTAGES-2:0] w_cause;
  logic [NSTAGES-1:0] w_stage_stall;
  logic [NSTAGES-2:0] w_stall;
  logic [NSTAGES-2:0] w_flush;
  logic               w_acc;
  logic               w_ld_use;
  logic               w_mem_wait;
  logic               w_br_fire;
  logic               w_exc_fire;

  assign w_live = {r_valid[NSTAGES-3:0], ifetch_ack_i};

  pipe_ctrl_hazard #(
    .NLD (MEM_STAGE-1)
  ) u_hazard (
    .i_id_rs1     (id_rs1_i),
    .i_id_rs2     (id_rs2_i),
    .i_id_use_rs1 (id_use_rs1_i),
    .i_id_use_rs2 (id_use_rs2_i),
    .i_ld_rd      (ld_rd_i),
    .i_ld_is      (ld_is_i),
    .i_ld_live    (w_live[MEM_STAGE:2]),
    .o_ld_use     (w_ld_use)
  );

  assign w_mem_wait = w_live[MEM_STAGE] & dmem_req_i & ~dmem_ack_i & ~dmem_err_i;

  always_comb begin
    w_cause            = '0;
    w_cause[STG_IF]    = ~ifetch_ack_i;
    w_cause[STG_ID]    = w_ld_use;
    w_cause[MEM_STAGE] = w_mem_wait;
  end

  // A stall propagates backwards: a stage stalls if it or any later stage
  // has a local cause. The fetch-wait cause only affects IF itself.
  always_comb begin
    w_acc                  = 1'b0;
    w_stage_stall          = '0;
    w_stage_stall[NSTAGES-1] = 1'b0;
    for (int s = NSTAGES-2; s >= 1; s--) begin
      w_acc            = w_acc | w_cause[s];
      w_stage_stall[s] = w_acc;
    end
    w_stage_stall[0] = w_acc | w_cause[0];
  end

  assign w_stall = w_stage_stall[NSTAGES-1:1];

  // A branch cannot redirect while its own stage is frozen.
  assign w_br_fire  = ~rst_i & br_j_taken_i & r_valid[BR_STAGE-1] &
                      ~w_stage_stall[BR_STAGE];
  assign w_exc_fire = ~rst_i & exc_taken_i & r_valid[NSTAGES-2];

  always_comb begin
    for (int k = 0; k < NSTAGES-1; k++) begin
      w_flush[k] = w_exc_fire | (w_br_fire & (k < BR_STAGE));
    end
  end

  assign stall_o  = rst_i ? '0 : w_stall;
  assign flush_o  = rst_i ? '1 : w_flush;
  assign valid_o  = r_valid;
  assign pc_sel_o = w_exc_fire ? PC_SEL_EXC : (w_br_fire ? PC_SEL_BR : PC_SEL_SEQ);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else begin
      for (int k = 0; k < NSTAGES-1; k++) begin
        if (w_flush[k]) begin
          r_valid[k] <= 1'b0;
        end else if (w_stall[k]) begin
          r_valid[k] <= r_valid[k];
        end else if (w_stage_stall[k]) begin
          // Upstream stage frozen while this register advances: insert bubble.
          r_valid[k] <= 1'b0;
        end else begin
          r_valid[k] <= w_live[k];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_ONE;
      // The WB instruction retires unless it is the one taking the trap.
      if (r_valid[NSTAGES-2] && !w_exc_fire) begin
        r_instret <= r_instret + CNT_ONE;
      end
    end
  end

  assign cycle_o   = r_cycle;
  assign instret_o = r_instret;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall[0]) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_br_fire || w_exc_fire) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl with default parameters (5 stages,
// branches in EXE, loads/stores in MEM). Reference model works on stage
// liveness and the index of the deepest stage that has a reason to stall.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int NS = 5;
  localparam int BR = 2;
  localparam int MS = 3;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ifetch_ack, dmem_req, dmem_ack, dmem_err;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic [9:0]  ld_rd;
  logic [1:0]  ld_is;
  logic        br, exc;
  logic [3:0]  stall_o, flush_o, valid_o;
  logic [1:0]  pc_sel_o;
  logic [63:0] cycle_o, instret_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  pipe_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ifetch_ack_i (ifetch_ack),
    .dmem_req_i   (dmem_req),
    .dmem_ack_i   (dmem_ack),
    .dmem_err_i   (dmem_err),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .ld_rd_i      (ld_rd),
    .ld_is_i      (ld_is),
    .br_j_taken_i (br),
    .exc_taken_i  (exc),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .valid_o      (valid_o),
    .pc_sel_o     (pc_sel_o),
    .cycle_o      (cycle_o),
    .instret_o    (instret_o),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  bit          mv [NS-1];
  bit          e_live [NS];
  int          e_top;
  bit          e_br, e_exc;
  logic [3:0]  e_stall, e_flush, e_valid;
  logic [1:0]  e_pc;
  logic [63:0] m_cycle = '0, m_instret = '0;
  logic [31:0] m_scnt = '0, m_fcnt = '0;

  task automatic model_eval();
    logic [4:0] rd;
    for (int s = 0; s < NS; s++) begin
      if (s == 0) e_live[s] = ifetch_ack;
      else        e_live[s] = mv[s-1];
    end
    // e_top: deepest stage with a reason to hold (-1 when none).
    e_top = -1;
    for (int s = 2; s <= MS; s++) begin
      rd = ld_rd[(s-2)*5 +: 5];
      if (e_live[s] && ld_is[s-2] && rd != 5'd0 &&
          ((id_use_rs1 && rd == id_rs1) || (id_use_rs2 && rd == id_rs2)))
        e_top = 1;
    end
    if (e_live[MS] && dmem_req && !dmem_ack && !dmem_err) e_top = MS;
    e_br  = !rst && br && mv[BR-1] && !(BR <= e_top);
    e_exc = !rst && exc && mv[NS-2];
    for (int k = 0; k < NS-1; k++) begin
      e_stall[k] = !rst && (k + 1 <= e_top);
      e_flush[k] = rst || e_exc || (e_br && k < BR);
      e_valid[k] = mv[k];
    end
    e_pc = e_exc ? 2'b10 : (e_br ? 2'b01 : 2'b00);
  endtask

  task automatic model_commit();
    bit nv [NS-1];
    if (rst) begin
      for (int k = 0; k < NS-1; k++) mv[k] = 1'b0;
      m_cycle = '0; m_instret = '0; m_scnt = '0; m_fcnt = '0;
    end else begin
      for (int k = 0; k < NS-1; k++) begin
        if (e_flush[k])                             nv[k] = 1'b0;
        else if (e_stall[k])                        nv[k] = mv[k];
        else if (k <= e_top || (k == 0 && !ifetch_ack)) nv[k] = 1'b0;
        else                                        nv[k] = e_live[k];
      end
      if (mv[NS-2] && !e_exc) m_instret = m_instret + 64'd1;
      m_cycle = m_cycle + 64'd1;
      if (e_stall[0])    m_scnt = m_scnt + 32'd1;
      if (e_br || e_exc) m_fcnt = m_fcnt + 32'd1;
      for (int k = 0; k < NS-1; k++) mv[k] = nv[k];
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic clear_inputs();
    ifetch_ack = 0; dmem_req = 0; dmem_ack = 0; dmem_err = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ld_rd = 0; ld_is = 0; br = 0; exc = 0;
  endtask

  task automatic sample(input bit chk);
    @(negedge clk);
    model_eval();
    if (chk) begin
      check("model.stall", stall_o, e_stall);
      check("model.flush", flush_o, e_flush);
      check("model.pc_sel", pc_sel_o, e_pc);
      if (!rst) begin
        check("model.valid", valid_o, e_valid);
        check("model.cycle", cycle_o, m_cycle);
        check("model.instret", instret_o, m_instret);
`ifdef PIPE_CTRL_PERF_EN
        check("model.stall_cnt", stall_cnt_o, m_scnt);
        check("model.flush_cnt", flush_cnt_o, m_fcnt);
`else
        check("model.stall_cnt", stall_cnt_o, 32'd0);
        check("model.flush_cnt", flush_cnt_o, 32'd0);
`endif
      end
    end
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    repeat (2) begin
      sample(1);
      advance();
    end
    rst = 0;
  endtask

  task automatic randomize_inputs();
    rst        = ($urandom_range(0, 199) == 0);
    ifetch_ack = ($urandom_range(0, 9) < 8);
    dmem_req   = ($urandom_range(0, 9) < 4);
    dmem_ack   = ($urandom_range(0, 2) == 0);
    dmem_err   = ($urandom_range(0, 9) == 0);
    id_rs1     = 5'($urandom_range(0, 3));
    id_rs2     = 5'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom_range(0, 1));
    id_use_rs2 = 1'($urandom_range(0, 1));
    ld_rd      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
    ld_is      = 2'($urandom_range(0, 3));
    br         = ($urandom_range(0, 6) == 0);
    exc        = ($urandom_range(0, 19) == 0);
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    logic       ack, req, dack, derr;
    logic [4:0] rs1;
    logic       u1;
    logic [9:0] ldrd;
    logic [1:0] ldis;
    logic       br, exc;
    logic [3:0] stall, flush, valid;
    logic [1:0] pc;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic ack, req, dack, derr, input logic [4:0] rs1,
                              input logic u1, input logic [9:0] ldrd, input logic [1:0] ldis,
                              input logic b, e, input logic [3:0] st, fl, va,
                              input logic [1:0] pc);
    vec_t v;
    v.ack = ack; v.req = req; v.dack = dack; v.derr = derr; v.rs1 = rs1; v.u1 = u1;
    v.ldrd = ldrd; v.ldis = ldis; v.br = b; v.exc = e;
    v.stall = st; v.flush = fl; v.valid = va; v.pc = pc;
    return v;
  endfunction

  // ------------------------------------------------------------- scoreboard
  logic [13:0] exp_q[$];

  initial begin
    logic [13:0] got;
    logic [3:0]  fill_v [6];
    rst = 1;
    clear_inputs();

    // Sequence: reset state then pipeline fill.
    fill_v[0] = 4'b0000; fill_v[1] = 4'b0001; fill_v[2] = 4'b0011;
    fill_v[3] = 4'b0111; fill_v[4] = 4'b1111; fill_v[5] = 4'b1111;
    do_reset();
    ifetch_ack = 1;
    for (int i = 0; i < 6; i++) begin
      sample(1);
      if (i == 0) begin
        check("rst.cycle", cycle_o, 64'd0);
        check("rst.instret", instret_o, 64'd0);
      end
      check($sformatf("fill.valid[%0d]", i), valid_o, fill_v[i]);
      check($sformatf("fill.pc[%0d]", i), pc_sel_o, 2'b00);
      advance();
    end
    sample(1);
    check("fill.instret", instret_o, 64'd2);
    check("fill.cycle", cycle_o, 64'd6);

    // Table: stalls, load-use, x0, branch, branch under MEM wait, trap.
    tbl[0]  = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b0000,2'b00);
    tbl[1]  = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b0001,2'b00);
    tbl[2]  = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b0011,2'b00);
    tbl[3]  = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b0111,2'b00);
    tbl[4]  = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b1111,2'b00);
    tbl[5]  = mk(1,0,0,0,5,1,10'd5,  2'b01,0,0, 4'b0001,4'b0000,4'b1111,2'b00);
    tbl[6]  = mk(1,1,0,0,5,1,10'd160,2'b10,0,0, 4'b0111,4'b0000,4'b1101,2'b00);
    tbl[7]  = mk(1,1,1,0,5,1,10'd160,2'b10,0,0, 4'b0001,4'b0000,4'b0101,2'b00);
    tbl[8]  = mk(1,0,0,0,5,1,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b1001,2'b00);
    tbl[9]  = mk(1,0,0,0,0,1,10'd0,  2'b01,0,0, 4'b0000,4'b0000,4'b0011,2'b00);
    tbl[10] = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b0111,2'b00);
    tbl[11] = mk(1,0,0,0,0,0,10'd0,  2'b00,1,0, 4'b0000,4'b0011,4'b1111,2'b01);
    tbl[12] = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b1100,2'b00);
    tbl[13] = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b1001,2'b00);
    tbl[14] = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b0011,2'b00);
    tbl[15] = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b0111,2'b00);
    tbl[16] = mk(1,1,0,0,0,0,10'd0,  2'b00,1,0, 4'b0111,4'b0000,4'b1111,2'b00);
    tbl[17] = mk(1,1,0,1,0,0,10'd0,  2'b00,1,0, 4'b0000,4'b0011,4'b0111,2'b01);
    tbl[18] = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b1100,2'b00);
    tbl[19] = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b1001,2'b00);
    tbl[20] = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b0011,2'b00);
    tbl[21] = mk(1,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b0111,2'b00);
    tbl[22] = mk(1,0,0,0,0,0,10'd0,  2'b00,1,1, 4'b0000,4'b1111,4'b1111,2'b10);
    tbl[23] = mk(0,0,0,0,0,0,10'd0,  2'b00,0,0, 4'b0000,4'b0000,4'b0000,2'b00);
    tbl[24] = mk(0,0,0,0,0,0,10'd0,  2'b00,0,1, 4'b0000,4'b0000,4'b0000,2'b00);

    advance();
    do_reset();
    for (int i = 0; i < NV; i++) begin
      clear_inputs();
      ifetch_ack = tbl[i].ack;  dmem_req = tbl[i].req;
      dmem_ack   = tbl[i].dack; dmem_err = tbl[i].derr;
      id_rs1     = tbl[i].rs1;  id_use_rs1 = tbl[i].u1;
      ld_rd      = tbl[i].ldrd; ld_is = tbl[i].ldis;
      br         = tbl[i].br;   exc = tbl[i].exc;
      exp_q.push_back({tbl[i].stall, tbl[i].flush, tbl[i].valid, tbl[i].pc});
      sample(1);
      got = exp_q.pop_front();
      check($sformatf("tbl[%0d]", i), {stall_o, flush_o, valid_o, pc_sel_o}, got);
      advance();
    end

    // Sequence: three-cycle bus wait completed by ack, then by err.
    do_reset();
    for (int e = 0; e < 2; e++) begin
      clear_inputs();
      ifetch_ack = 1;
      repeat (4) begin sample(1); advance(); end
      dmem_req = 1;
      for (int w = 0; w < 3; w++) begin
        sample(1);
        check($sformatf("wait%0d.stall[%0d]", e, w), stall_o, 4'b0111);
        if (w > 0) check($sformatf("wait%0d.valid3[%0d]", e, w), valid_o[3], 1'b0);
        advance();
      end
      if (e == 0) dmem_ack = 1;
      else        dmem_err = 1;
      sample(1);
      check($sformatf("wait%0d.done", e), stall_o, 4'b0000);
      advance();
    end

    // Sequence: trap and branch together; retire count must not move.
    do_reset();
    clear_inputs();
    ifetch_ack = 1;
    repeat (5) begin sample(1); advance(); end
    br = 1; exc = 1;
    sample(1);
    check("trap.pc_sel", pc_sel_o, 2'b10);
    check("trap.flush", flush_o, 4'b1111);
    check("trap.instret_before", instret_o, 64'd1);
    advance();
    br = 0; exc = 0;
    sample(1);
    check("trap.instret_after", instret_o, 64'd1);
    check("trap.valid_after", valid_o, 4'b0000);
`ifdef PIPE_CTRL_PERF_EN
    check("trap.flush_cnt", flush_cnt_o, 32'd1);
`else
    check("trap.flush_cnt", flush_cnt_o, 32'd0);
`endif
    advance();

    // Sequence: reset arrives while MEM waits on the bus.
    clear_inputs();
    ifetch_ack = 1;
    repeat (4) begin sample(1); advance(); end
    dmem_req = 1;
    sample(1); advance();
    rst = 1;
    sample(1);
    check("rstwait.stall", stall_o, 4'b0000);
    check("rstwait.flush", flush_o, 4'b1111);
    check("rstwait.pc_sel", pc_sel_o, 2'b00);
    advance();
    rst = 0;
    clear_inputs();
    sample(1);
    check("rstwait.valid", valid_o, 4'b0000);
    check("rstwait.cycle", cycle_o, 64'd0);
    advance();

    // Randomised run against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      sample(1);
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
